// File: rtl/cia_pkg.sv
// Shared constants for the CIA interval timer: register addresses, control
// register bit positions and the mode encodings carried by those bits.
package cia_pkg;

  localparam logic [1:0] ADDR_TLO = 2'd0;
  localparam logic [1:0] ADDR_THI = 2'd1;
  localparam logic [1:0] ADDR_CR  = 2'd2;

  localparam int CR_START   = 0;
  localparam int CR_PBON    = 1;
  localparam int CR_OUTMODE = 2;
  localparam int CR_RUNMODE = 3;
  localparam int CR_LOAD    = 4;
  localparam int CR_INMODE  = 5;

  typedef enum logic {INMODE_ECLK   = 1'b0, INMODE_EXT     = 1'b1} inmode_e;
  typedef enum logic {OUTMODE_PULSE = 1'b0, OUTMODE_TOGGLE = 1'b1} outmode_e;
  typedef enum logic {RUNMODE_CONT  = 1'b0, RUNMODE_ONESHOT = 1'b1} runmode_e;

endpackage

// File: rtl/cia_timer_if.sv
// CPU-side register bus of one timer: select, write strobe, address and data.
interface cia_timer_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output cs, we, addr, data_in, input data_out);
  modport slave  (input cs, we, addr, data_in, output data_out);
endinterface

// File: rtl/cia_tick_sel.sv
// Count-source selection: one qualified tick per E period, or per rising edge
// of the external source as seen on 7 MHz enable cycles.
module cia_tick_sel
  import cia_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    clk7_en,
  input  logic    eclk_stb,
  input  logic    ext_tick,
  input  inmode_e inmode,
  output logic    tick
);

  logic ext_q, ext_d;

  // History is kept in both modes so switching to external count cannot
  // manufacture a spurious edge from a stale sample.
  always_comb ext_d = clk7_en ? ext_tick : ext_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ext_q <= 1'b0;
    else          ext_q <= ext_d;
  end

  always_comb begin
    tick = 1'b0;
    if (clk7_en) begin
      if (inmode == INMODE_EXT) tick = ext_tick & ~ext_q;
      else                      tick = eclk_stb;
    end
  end

endmodule

// File: rtl/cia_timer.sv
// 16-bit CIA-style interval timer: latch/counter/control registers, underflow
// strobe and PB6/PB7-style port output in pulse or toggle mode.
module cia_timer
  import cia_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic        eclk_stb,
  input  logic        ext_tick,
  cia_timer_if.slave  bus,
  output logic        uf,
  output logic        pb_out,
  output logic        pb_oe
);

  logic [15:0] latch_q, latch_d, counter_q, counter_d;
  logic [7:0]  cr_q, cr_d, dout_q, dout_d;
  logic        uf_q, pulse_q, pulse_d, toggle_q, toggle_d;
  logic        wr, tick, load, underflow;

  cia_tick_sel u_tick_sel (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk7_en  (clk7_en),
    .eclk_stb (eclk_stb),
    .ext_tick (ext_tick),
    .inmode   (inmode_e'(cr_q[CR_INMODE])),
    .tick     (tick)
  );

  assign wr = bus.cs & bus.we & clk7_en;

  always_comb begin
    latch_d   = latch_q;
    counter_d = counter_q;
    cr_d      = cr_q;
    load      = 1'b0;
    underflow = 1'b0;
    pulse_d   = pulse_q;
    toggle_d  = toggle_q;

    if (wr) begin
      case (bus.addr)
        ADDR_TLO: latch_d[7:0] = bus.data_in;
        ADDR_THI: begin
          latch_d[15:8] = bus.data_in;
          if (!cr_q[CR_START]) begin
            counter_d = {bus.data_in, latch_q[7:0]};
            load      = 1'b1;
            if (runmode_e'(cr_q[CR_RUNMODE]) == RUNMODE_ONESHOT) cr_d[CR_START] = 1'b1;
          end
        end
        ADDR_CR: begin
          cr_d          = bus.data_in;
          cr_d[CR_LOAD] = 1'b0;
          if (bus.data_in[CR_LOAD]) begin
            counter_d = latch_q;
            load      = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Counting sees the post-write START, so a stop written on an underflow
    // tick suppresses it, and any counter load overrides the tick.
    if (tick && cr_d[CR_START] && !load) begin
      if (counter_q == 16'd0) begin
        counter_d = latch_q;
        underflow = 1'b1;
        if (runmode_e'(cr_d[CR_RUNMODE]) == RUNMODE_ONESHOT) cr_d[CR_START] = 1'b0;
      end else begin
        counter_d = counter_q - 16'd1;
      end
    end

    if (underflow)  pulse_d = 1'b1;
    else if (tick)  pulse_d = 1'b0;

    if (underflow)                             toggle_d = ~toggle_q;
    else if (!cr_q[CR_START] && cr_d[CR_START]) toggle_d = 1'b1;
  end

  always_comb begin
    dout_d = 8'h00;
    if (bus.cs && !bus.we) begin
      case (bus.addr)
        ADDR_TLO: dout_d = counter_q[7:0];
        ADDR_THI: dout_d = counter_q[15:8];
        ADDR_CR:  dout_d = cr_q;
        default:  dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_q   <= 16'hFFFF;
      counter_q <= 16'hFFFF;
      cr_q      <= 8'h00;
      dout_q    <= 8'h00;
      uf_q      <= 1'b0;
      pulse_q   <= 1'b0;
      toggle_q  <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      counter_q <= counter_d;
      cr_q      <= cr_d;
      dout_q    <= dout_d;
      uf_q      <= underflow;
      pulse_q   <= pulse_d;
      toggle_q  <= toggle_d;
    end
  end

  assign bus.data_out = dout_q;
  assign uf           = uf_q;
  assign pb_oe        = cr_q[CR_PBON];
  assign pb_out       = (outmode_e'(cr_q[CR_OUTMODE]) == OUTMODE_TOGGLE) ? toggle_q : pulse_q;

endmodule

// File: tb/tb_cia_timer.sv
// Bench for cia_timer: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against an event-level model.
module tb_cia_timer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clk7_en = 1'b0;
  logic eclk_stb = 1'b0;
  logic ext_tick = 1'b0;
  logic uf, pb_out, pb_oe;

  cia_timer_if bus ();

  cia_timer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk7_en  (clk7_en),
    .eclk_stb (eclk_stb),
    .ext_tick (ext_tick),
    .bus      (bus),
    .uf       (uf),
    .pb_out   (pb_out),
    .pb_oe    (pb_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void dchk(string name, int act, int exp);
    $display("check %-14s got 0x%0h want 0x%0h", name, act, exp);
    chk(name, act, exp);
  endfunction

  // ---------------- behavioural model ----------------
  int       m_latch, m_cnt;
  bit [7:0] m_cr;
  bit       m_ext_prev, m_pulse, m_toggle;
  int       e_dout;
  bit       e_uf, e_pb, e_oe;

  // Apply one clk cycle worth of the timer's rules to the model.
  task automatic model_step();
    int  old_latch, rd_val, d;
    bit  tick, wr, was_run, loaded, under;
    if (!reset_n) begin
      m_latch = 'hFFFF; m_cnt = 'hFFFF; m_cr = 8'h00;
      m_ext_prev = 0; m_pulse = 0; m_toggle = 0;
      e_dout = 0; e_uf = 0; e_pb = 0; e_oe = 0;
      return;
    end
    rd_val = 0;
    if (bus.cs && !bus.we) begin
      case (bus.addr)
        2'd0: rd_val = m_cnt % 256;
        2'd1: rd_val = m_cnt / 256;
        2'd2: rd_val = m_cr;
        default: rd_val = 0;
      endcase
    end
    tick = 0;
    if (clk7_en) begin
      tick = m_cr[5] ? (ext_tick && !m_ext_prev) : eclk_stb;
      m_ext_prev = ext_tick;
    end
    old_latch = m_latch;
    was_run   = m_cr[0];
    loaded    = 0;
    d         = bus.data_in;
    wr        = bus.cs && bus.we && clk7_en;
    if (wr) begin
      case (bus.addr)
        2'd0: m_latch = (m_latch / 256) * 256 + d;
        2'd1: begin
          m_latch = d * 256 + (m_latch % 256);
          if (!was_run) begin
            m_cnt = m_latch;
            loaded = 1;
            if (m_cr[3]) m_cr[0] = 1;
          end
        end
        2'd2: begin
          m_cr = 8'(d) & 8'hEF;
          if ((d / 16) % 2 == 1) begin
            m_cnt = old_latch;
            loaded = 1;
          end
        end
        default: ;
      endcase
    end
    under = 0;
    if (tick && m_cr[0] && !loaded) begin
      if (m_cnt == 0) begin
        under = 1;
        m_cnt = old_latch;
        if (m_cr[3]) m_cr[0] = 0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    if (under)     m_pulse = 1;
    else if (tick) m_pulse = 0;
    if (under)                    m_toggle = !m_toggle;
    else if (!was_run && m_cr[0]) m_toggle = 1;
    e_dout = rd_val;
    e_uf   = under;
    e_pb   = m_cr[2] ? m_toggle : m_pulse;
    e_oe   = m_cr[1];
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("data_out", bus.data_out, e_dout);
    chk("uf", uf, e_uf);
    chk("pb_out", pb_out, e_pb);
    chk("pb_oe", pb_oe, e_oe);
  end

  // ---------------- stimulus helpers ----------------
  int ph = 0, eph = 0, e_div = 3;
  bit e_on = 0;
  int ticks = 0, ufs = 0;

  task automatic step();
    @(negedge clk);
    if (uf) ufs++;
    ph = (ph + 1) % 4;
    clk7_en = (ph == 0);
    if (clk7_en) eph = (eph + 1) % e_div;
    eclk_stb = e_on && (eph == 0);
    if (clk7_en && eclk_stb) ticks++;
  endtask

  task automatic wr(input int a, input int d);
    do step(); while (!clk7_en);
    bus.cs = 1; bus.we = 1; bus.addr = a[1:0]; bus.data_in = d[7:0];
    step();
    bus.cs = 0; bus.we = 0; bus.data_in = 8'h00;
    $display("write addr=%0d data=0x%02h", a, d);
  endtask

  task automatic rd(input int a, output int d);
    step();
    bus.cs = 1; bus.we = 0; bus.addr = a[1:0];
    step();
    d = bus.data_out;
    bus.cs = 0;
  endtask

  task automatic expect_rd(input string name, input int a, input int exp);
    int v;
    rd(a, v);
    dchk(name, v, exp);
  endtask

  task automatic run_ticks(input int n);
    int t0 = ticks;
    int budget = 0;
    while (ticks - t0 < n && budget < 2000) begin
      step();
      budget++;
    end
    chk("tick_budget", (ticks - t0 >= n) ? 1 : 0, 1);
    repeat (3) step();
  endtask

  // CR write landing on the same clk7 cycle as an E tick.
  task automatic collide(input int d);
    do step(); while (!clk7_en);
    eclk_stb = 1;
    bus.cs = 1; bus.we = 1; bus.addr = 2'd2; bus.data_in = d[7:0];
    step();
    bus.cs = 0; bus.we = 0; bus.data_in = 8'h00;
    repeat (3) step();
    $display("collide CR write data=0x%02h with tick", d);
  endtask

  int seq[$];
  int exp_seq[9] = '{3, 2, 1, 0, 3, 2, 1, 0, 3};
  int exp_tog[6] = '{1, 0, 0, 1, 1, 0};

  initial begin
    bus.cs = 0; bus.we = 0; bus.addr = 2'd0; bus.data_in = 8'h00;

    // Reset state
    repeat (3) step();
    dchk("rst_uf", uf, 0);
    dchk("rst_pb_out", pb_out, 0);
    dchk("rst_pb_oe", pb_oe, 0);
    dchk("rst_dout", bus.data_out, 0);
    reset_n = 1;
    expect_rd("rst_tlo", 0, 'hFF);
    expect_rd("rst_thi", 1, 'hFF);
    expect_rd("rst_cr", 2, 'h00);

    // Continuous count, latch 3
    wr(0, 3); wr(1, 0); wr(2, 'h01);
    ufs = 0;
    bus.cs = 1; bus.we = 0; bus.addr = 2'd0; e_on = 1;
    step();
    for (int b = 0; b < 800 && seq.size() < 9; b++) begin
      if (seq.size() == 0 || seq[$] != int'(bus.data_out)) seq.push_back(int'(bus.data_out));
      if (seq.size() < 9) step();
    end
    bus.cs = 0; e_on = 0;
    for (int i = 0; i < 9; i++)
      dchk($sformatf("cont_seq%0d", i), (i < seq.size()) ? seq[i] : -1, exp_seq[i]);
    dchk("cont_ufs", ufs, 2);
    wr(2, 0);

    // One-shot started by THI write
    wr(2, 'h08); wr(0, 2); wr(1, 0);
    expect_rd("os_cr_run", 2, 'h09);
    ufs = 0; e_on = 1;
    run_ticks(3);
    e_on = 0;
    dchk("os_ufs", ufs, 1);
    expect_rd("os_cr_stop", 2, 'h08);
    expect_rd("os_tlo", 0, 'h02);
    expect_rd("os_thi", 1, 'h00);
    ufs = 0; e_on = 1;
    run_ticks(3);
    e_on = 0;
    dchk("os_hold_ufs", ufs, 0);
    expect_rd("os_hold_tlo", 0, 'h02);

    // Toggle output, latch 1
    wr(2, 0); wr(0, 1); wr(1, 0); wr(2, 'h07);
    step();
    dchk("tog_pb_oe", pb_oe, 1);
    dchk("tog_start", pb_out, 1);
    e_on = 1;
    for (int k = 0; k < 6; k++) begin
      run_ticks(1);
      dchk($sformatf("tog_tick%0d", k + 1), pb_out, exp_tog[k]);
    end
    e_on = 0;
    wr(2, 0);

    // Force load colliding with an underflow tick
    wr(0, 0); wr(1, 0); wr(0, 7); wr(2, 'h01);
    ufs = 0;
    collide('h11);
    dchk("fl_ufs", ufs, 0);
    expect_rd("fl_tlo", 0, 7);
    expect_rd("fl_cr", 2, 'h01);

    // Stop written on an underflow tick
    wr(2, 0); wr(0, 0); wr(1, 0); wr(2, 'h01);
    ufs = 0;
    collide('h00);
    dchk("stop_ufs", ufs, 0);
    expect_rd("stop_tlo", 0, 0);

    // External count source, latch 1, E strobe still running
    wr(2, 0); wr(0, 1); wr(1, 0); wr(2, 'h21);
    e_on = 1;
    for (int i = 1; i <= 5; i++) begin
      ufs = 0;
      ext_tick = 1; repeat (12) step();
      ext_tick = 0; repeat (12) step();
      dchk($sformatf("ext_edge%0d", i), ufs, (i == 2 || i == 4) ? 1 : 0);
    end
    e_on = 0;
    wr(2, 0);

    // Reset mid-count
    wr(0, 5); wr(1, 0); wr(2, 'h03);
    e_on = 1;
    repeat (30) step();
    dchk("pre_rst_pb_oe", pb_oe, 1);
    reset_n = 0;
    #1;
    dchk("async_pb_oe", pb_oe, 0);
    dchk("async_uf", uf, 0);
    repeat (3) step();
    dchk("mid_rst_pb_out", pb_out, 0);
    reset_n = 1; e_on = 0;
    expect_rd("mid_rst_tlo", 0, 'hFF);
    expect_rd("mid_rst_thi", 1, 'hFF);
    expect_rd("mid_rst_cr", 2, 'h00);

    // Randomized traffic, checked by the model every cycle
    e_on = 1;
    for (int c = 0; c < 4000; c++) begin
      step();
      reset_n = ($urandom_range(0, 999) != 0);
      bus.cs = ($urandom_range(0, 3) == 0);
      bus.we = 1'($urandom_range(0, 1));
      bus.addr = 2'($urandom_range(0, 3));
      case (bus.addr)
        2'd0: bus.data_in = 8'($urandom_range(0, 6));
        2'd1: bus.data_in = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
        default: bus.data_in = 8'($urandom_range(0, 255)) | (($urandom_range(0, 3) != 0) ? 8'h01 : 8'h00);
      endcase
      if ($urandom_range(0, 5) == 0) ext_tick = ~ext_tick;
      if (bus.cs && bus.we && clk7_en)
        $display("rand write addr=%0d data=0x%02h", bus.addr, bus.data_in);
    end
    bus.cs = 0; bus.we = 0; reset_n = 1; e_on = 0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
